jt5911_eeprom: RTL and testbench

Serial EEPROM controller emulating a 93C46-class device organised as 64 × 16-bit words, driven by a CPU bit-banging chip select, clock and data through latched I/O bits. Array storage lives in an external 128 × 8 byte RAM, the system NVRAM, accessed through the `mem_*` port. A status flag tells the host when contents change so the NVRAM can be saved.

---
 rtl/jt5911_pkg.sv | 19 +
 rtl/jt5911_memseq.sv | 103 ++++++++++
 rtl/jt5911_eeprom.sv | 177 +++++++++++++++++
 tb/tb_jt5911_eeprom.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt5911_pkg.sv
// Shared encodings for the 93C46-style serial EEPROM emulation.
package jt5911_pkg;

  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  // Extended sub-commands live in address bits [5:4] when the opcode is OP_EXT
  localparam logic [1:0] SUB_EWDS = 2'b00;
  localparam logic [1:0] SUB_WRAL = 2'b01;
  localparam logic [1:0] SUB_ERAL = 2'b10;
  localparam logic [1:0] SUB_EWEN = 2'b11;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA_IN, READ_OUT, DONE
  } fe_state_t;

endpackage

// File: rtl/jt5911_memseq.sv
// Byte sequencer toward the NVRAM: 16-bit word fetches and program/erase
// write bursts, with the busy timer that drives rdy.
module jt5911_memseq #(
  parameter int PROG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_go,
  input  logic        prog_all,
  input  logic [5:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic        rd_req,
  input  logic [5:0]  rd_addr,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        rdy,
  output logic [6:0]  mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout
);

  localparam int CW = $clog2(PROG_CYCLES + 1);

  logic          busy, wr_act, ph;
  logic [6:0]    bidx, last;
  logic [15:0]   wdata;
  logic [CW-1:0] cyc;
  logic [1:0]    rd_st;
  logic [5:0]    rd_a;

  assign rdy = ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      wr_act   <= 1'b0;
      ph       <= 1'b0;
      bidx     <= '0;
      last     <= '0;
      wdata    <= '0;
      cyc      <= '0;
      rd_st    <= '0;
      rd_a     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      rd_valid <= 1'b0;
      if (prog_go && !busy) begin
        busy   <= 1'b1;
        wr_act <= 1'b1;
        ph     <= 1'b0;
        cyc    <= '0;
        wdata  <= prog_data;
        bidx   <= prog_all ? 7'd0 : {prog_addr, 1'b0};
        last   <= prog_all ? 7'h7f : {prog_addr, 1'b1};
      end else if (busy) begin
        if (cyc != CW'(PROG_CYCLES)) cyc <= cyc + 1'b1;
        // one strobe cycle then one idle cycle per byte
        if (wr_act) begin
          if (!ph) begin
            mem_we   <= 1'b1;
            mem_addr <= bidx;
            mem_din  <= bidx[0] ? wdata[15:8] : wdata[7:0];
            ph       <= 1'b1;
          end else begin
            ph <= 1'b0;
            if (bidx == last) wr_act <= 1'b0;
            else              bidx   <= bidx + 7'd1;
          end
        end else if (cyc == CW'(PROG_CYCLES)) begin
          busy <= 1'b0;
        end
      end
      // word fetch: low byte address, high byte address, then two captures
      case (rd_st)
        2'd0: if (rd_req) begin
          mem_addr <= {rd_addr, 1'b0};
          rd_a     <= rd_addr;
          rd_st    <= 2'd1;
        end
        2'd1: begin
          mem_addr <= {rd_a, 1'b1};
          rd_st    <= 2'd2;
        end
        2'd2: begin
          rd_data[7:0] <= mem_dout;
          rd_st        <= 2'd3;
        end
        default: begin
          rd_data[15:8] <= mem_dout;
          rd_valid      <= 1'b1;
          rd_st         <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/jt5911_eeprom.sv
// 93C46-class serial EEPROM front-end: decodes bit-banged commands and hands
// reads and program/erase jobs to the NVRAM byte sequencer.
module jt5911_eeprom import jt5911_pkg::*; #(
  parameter SIMFILE         = "",
  parameter int PROG_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       sdi,
  output logic       sdo,
  output logic       rdy,
  input  logic       scs,
  output logic [6:0] mem_addr,
  output logic [7:0] mem_din,
  output logic       mem_we,
  input  logic [7:0] mem_dout,
  input  logic       dump_clr,
  output logic       dump_flag
);

  // The file name only matters to the memory model outside this block
  if (SIMFILE != "") begin : g_simfile
  end

  fe_state_t   state, state_n;
  logic        sclk_r, sclk_l, scs_r, scs_l, sdi_r;
  logic [3:0]  cnt, cnt_n;
  logic [1:0]  op, op_n;
  logic [5:0]  addr, addr_n;
  logic [15:0] sh, sh_n;
  logic        wen, wen_n, sdo_q, sdo_n;
  logic        rise, scs_fall, rd_req, prog_go, prog_cmd, prog_all, rd_valid;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data, prog_data;
  logic [5:0]  addr_sh;

  assign rise     = sclk_r & ~sclk_l;
  assign scs_fall = scs_l & ~scs_r;
  assign addr_sh  = {addr[4:0], sdi_r};

  assign prog_all  = (op == OP_EXT);
  assign prog_cmd  = (op == OP_WRITE) || (op == OP_ERASE) ||
                     (op == OP_EXT && (addr[5:4] == SUB_ERAL || addr[5:4] == SUB_WRAL));
  assign prog_data = (op == OP_ERASE || (op == OP_EXT && addr[5:4] == SUB_ERAL))
                     ? 16'hffff : sh;

  assign sdo = (state == READ_OUT) ? sdo_q : (scs_r ? rdy : 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_r    <= 1'b0;
      sclk_l    <= 1'b0;
      scs_r     <= 1'b0;
      scs_l     <= 1'b0;
      sdi_r     <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      addr      <= '0;
      sh        <= '0;
      wen       <= 1'b0;
      sdo_q     <= 1'b1;
      dump_flag <= 1'b0;
    end else begin
      sclk_r <= sclk;
      sclk_l <= sclk_r;
      scs_r  <= scs;
      scs_l  <= scs_r;
      sdi_r  <= sdi;
      state  <= state_n;
      cnt    <= cnt_n;
      op     <= op_n;
      addr   <= addr_n;
      sh     <= sh_n;
      wen    <= wen_n;
      sdo_q  <= sdo_n;
      if (mem_we)        dump_flag <= 1'b1;
      else if (dump_clr) dump_flag <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op;
    addr_n  = addr;
    sh_n    = sh;
    wen_n   = wen;
    sdo_n   = sdo_q;
    rd_req  = 1'b0;
    rd_addr = addr;
    prog_go = 1'b0;
    if (!scs_r) begin
      state_n = IDLE;
      prog_go = scs_fall && state == DONE && prog_cmd && wen;
    end else begin
      if (state == READ_OUT && rd_valid) sh_n = rd_data;
      if (rise) begin
        case (state)
          IDLE: if (sdi_r && rdy) begin
            state_n = CMD;
            cnt_n   = '0;
          end
          CMD: begin
            op_n  = {op[0], sdi_r};
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd1) begin
              state_n = ADDR;
              cnt_n   = '0;
            end
          end
          ADDR: begin
            addr_n = addr_sh;
            cnt_n  = cnt + 4'd1;
            if (cnt == 4'd5) begin
              cnt_n   = '0;
              state_n = DONE;
              case (op)
                OP_READ: begin
                  state_n = READ_OUT;
                  sdo_n   = 1'b0;
                  rd_req  = 1'b1;
                  rd_addr = addr_sh;
                end
                OP_WRITE: state_n = DATA_IN;
                OP_ERASE: ;
                default: case (addr_sh[5:4])
                  SUB_EWEN: wen_n   = 1'b1;
                  SUB_EWDS: wen_n   = 1'b0;
                  SUB_WRAL: state_n = DATA_IN;
                  default: ;
                endcase
              endcase
            end
          end
          DATA_IN: begin
            sh_n  = {sh[14:0], sdi_r};
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd15) state_n = DONE;
          end
          READ_OUT: begin
            // after bit 0 the next word is fetched before the following edge
            sdo_n = sh[15];
            sh_n  = {sh[14:0], 1'b0};
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd15) begin
              addr_n  = addr + 6'd1;
              rd_req  = 1'b1;
              rd_addr = addr + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  jt5911_memseq #(.PROG_CYCLES(PROG_CYCLES)) u_memseq (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_go   (prog_go),
    .prog_all  (prog_all),
    .prog_addr (addr),
    .prog_data (prog_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rdy       (rdy),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout)
  );

endmodule

// File: tb/tb_jt5911_eeprom.sv
// Bench for jt5911_eeprom: serial command driver, NVRAM model and a
// scoreboard of expected byte writes and expected sdo bits.
module tb_jt5911_eeprom;

  logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, sdi = 1'b0, scs = 1'b0, dump_clr = 1'b0;
  logic       sdo, rdy, mem_we, dump_flag;
  logic [6:0] mem_addr;
  logic [7:0] mem_din, mem_dout;
  logic [7:0] ram [0:127];

  int checks = 0, errors = 0, we_cnt = 0, we_rdy = 0;
  logic [14:0] exp_wr[$];
  logic        exp_bit[$];

  jt5911_eeprom #(.SIMFILE(""), .PROG_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdi(sdi), .sdo(sdo), .rdy(rdy), .scs(scs),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .dump_clr(dump_clr), .dump_flag(dump_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  // write scoreboard
  always @(negedge clk) begin
    if (mem_we) begin
      logic [14:0] e;
      we_cnt++;
      if (rdy) we_rdy++;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we addr=%0d data=%02h", mem_addr, mem_din);
      end else begin
        e = exp_wr.pop_front();
        if ({mem_addr, mem_din} !== e) begin
          errors++;
          $display("FAIL wr_byte got %0d/%02h exp %0d/%02h", mem_addr, mem_din, e[14:8], e[7:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b);
    sclk = 1'b0; sdi = b; tick(5);
    sclk = 1'b1; tick(5);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) clk_bit(v[i]);
  endtask

  task automatic frame_start;
    sclk = 1'b0; scs = 1'b1; tick(3);
  endtask

  task automatic frame_end;
    sclk = 1'b0; tick(2); scs = 1'b0; tick(3);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [5:0] a);
    send_bits({23'd0, 1'b1, op, a}, 9);
  endtask

  task automatic ext(input logic [1:0] sub);
    frame_start; cmd(2'b00, {sub, 4'b0000}); frame_end;
  endtask

  task automatic do_reset;
    scs = 1'b0; sclk = 1'b0; sdi = 1'b0; rst_n = 1'b0; tick(3); rst_n = 1'b1; tick(3);
  endtask

  task automatic read_check(input string name);
    while (exp_bit.size() != 0) begin
      logic e;
      clk_bit(1'b0);
      e = exp_bit.pop_front();
      checks++;
      if (sdo !== e) begin
        errors++;
        $display("FAIL %s got %b exp %b", name, sdo, e);
      end
    end
  endtask

  // ignored command: no writes, rdy held high for a while
  task automatic expect_idle(input string name);
    int w0, low;
    w0 = we_cnt; low = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (!rdy) low++;
    end
    checks++;
    if (we_cnt !== w0 || low != 0) begin
      errors++;
      $display("FAIL %s writes=%0d rdy_low=%0d exp 0/0", name, we_cnt - w0, low);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tick(2); #1;
    checks += 6;
    if (sdo !== 1'b1)      begin errors++; $display("FAIL rst_sdo got %b exp 1", sdo); end
    if (rdy !== 1'b1)      begin errors++; $display("FAIL rst_rdy got %b exp 1", rdy); end
    if (mem_we !== 1'b0)   begin errors++; $display("FAIL rst_we got %b exp 0", mem_we); end
    if (mem_addr !== 7'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", mem_addr); end
    if (mem_din !== 8'd0)  begin errors++; $display("FAIL rst_din got %0d exp 0", mem_din); end
    if (dump_flag !== 1'b0) begin errors++; $display("FAIL rst_dump got %b exp 0", dump_flag); end
    rst_n = 1'b1; tick(3);
  endtask

  task automatic test_write;
    int t, low;
    ext(2'b11);
    exp_wr.push_back({7'd10, 8'h34});
    exp_wr.push_back({7'd11, 8'h12});
    frame_start; cmd(2'b01, 6'd5); send_bits(32'h1234, 16); send_bits(32'h3, 2); frame_end;
    t = 0; low = 0;
    while (rdy && t < 10) begin tick(1); t++; end
    while (!rdy && low < 2000) begin tick(1); low++; end
    checks += 3;
    if (low < 64 || low >= 2000) begin errors++; $display("FAIL write_busy got %0d exp >=64", low); end
    if (exp_wr.size() != 0) begin errors++; $display("FAIL write_left got %0d exp 0", exp_wr.size()); end
    if (dump_flag !== 1'b1) begin errors++; $display("FAIL dump_set got %b exp 1", dump_flag); end
    dump_clr = 1'b1; tick(1); dump_clr = 1'b0; tick(1);
    checks++;
    if (dump_flag !== 1'b0) begin errors++; $display("FAIL dump_clr got %b exp 0", dump_flag); end
    exp_wr.delete();
  endtask

  task automatic test_read;
    logic [15:0] w;
    ram[10] = 8'hef; ram[11] = 8'hbe; w = 16'hbeef;
    frame_start; cmd(2'b10, 6'd5);
    checks++;
    if (sdo !== 1'b0) begin errors++; $display("FAIL read_dummy got %b exp 0", sdo); end
    for (int i = 15; i >= 0; i--) exp_bit.push_back(w[i]);
    read_check("read_bit");
    frame_end;
  endtask

  task automatic test_read_wrap;
    logic [31:0] w;
    ram[126] = 8'hc3; ram[127] = 8'ha5; ram[0] = 8'h0f; ram[1] = 8'h1e;
    w = 32'ha5c3_1e0f;
    frame_start; cmd(2'b10, 6'd63);
    checks++;
    if (sdo !== 1'b0) begin errors++; $display("FAIL wrap_dummy got %b exp 0", sdo); end
    for (int i = 31; i >= 0; i--) exp_bit.push_back(w[i]);
    read_check("wrap_bit");
    frame_end;
  endtask

  task automatic test_wen_block;
    do_reset;
    frame_start; cmd(2'b01, 6'd2); send_bits(32'h5555, 16); frame_end;
    expect_idle("wdis_after_reset");
    ext(2'b11); ext(2'b00);
    frame_start; cmd(2'b01, 6'd2); send_bits(32'h5555, 16); frame_end;
    expect_idle("wdis_after_ewds");
    ext(2'b11);
    frame_start; cmd(2'b01, 6'd2); send_bits(32'h55, 8); frame_end;
    expect_idle("partial_frame");
  endtask

  task automatic test_eral;
    int t, w0;
    w0 = we_cnt; we_rdy = 0;
    ext(2'b11);
    for (int i = 0; i < 128; i++) exp_wr.push_back({i[6:0], 8'hff});
    frame_start; cmd(2'b00, 6'b100000); frame_end;
    scs = 1'b1; tick(3);
    checks++;
    if (rdy !== 1'b0 || sdo !== 1'b0) begin
      errors++; $display("FAIL eral_busy rdy=%b sdo=%b exp 0/0", rdy, sdo);
    end
    t = 0;
    while (!rdy && t < 1000) begin tick(1); t++; end
    tick(1);
    checks += 4;
    if (t >= 1000 || t < 250) begin errors++; $display("FAIL eral_time got %0d exp 250..999", t); end
    if (sdo !== 1'b1) begin errors++; $display("FAIL eral_sdo_ready got %b exp 1", sdo); end
    if (we_cnt - w0 != 128) begin errors++; $display("FAIL eral_count got %0d exp 128", we_cnt - w0); end
    if (we_rdy != 0) begin errors++; $display("FAIL eral_we_while_rdy got %0d exp 0", we_rdy); end
    scs = 1'b0; tick(3);
  endtask

  task automatic test_reset_mid;
    int w0, w1;
    w0 = we_cnt;
    ext(2'b11);
    for (int i = 0; i < 128; i++) exp_wr.push_back({i[6:0], i[0] ? 8'h5a : 8'ha5});
    frame_start; cmd(2'b00, 6'b010000); send_bits(32'h5aa5, 16); frame_end;
    tick(40);
    rst_n = 1'b0; #1;
    checks++;
    if (rdy !== 1'b1 || sdo !== 1'b1) begin
      errors++; $display("FAIL abort_outputs rdy=%b sdo=%b exp 1/1", rdy, sdo);
    end
    tick(3); rst_n = 1'b1;
    w1 = we_cnt;
    tick(20);
    checks += 2;
    if (we_cnt != w1) begin errors++; $display("FAIL abort_stop got %0d exp 0 more writes", we_cnt - w1); end
    if (w1 - w0 < 1 || w1 - w0 > 127) begin
      errors++; $display("FAIL abort_partial got %0d exp 1..127", w1 - w0);
    end
    exp_wr.delete();
    frame_start; cmd(2'b01, 6'd7); send_bits(32'h1111, 16); frame_end;
    expect_idle("write_after_abort");
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 8'h00;
    test_reset;
    test_write;
    test_read;
    test_wen_block;
    test_read_wrap;
    test_eral;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
